// File: rtl/wimax_intlv_pkg.sv
// Shared types and mode helpers for the multi-mode 802.16 block interleaver.
// Optional bypass path is enabled by defining INTLV_BYPASS_EN.
package wimax_intlv_pkg;

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'd0,
    MOD_QPSK  = 2'd1,
    MOD_16QAM = 2'd2,
    MOD_64QAM = 2'd3
  } mod_e;

  localparam int D_DEF        = 16;
  localparam int N_SUB_DEF    = 96;
  localparam int MAX_NCPC_DEF = 6;
  localparam int MAX_NCBPS    = N_SUB_DEF * MAX_NCPC_DEF;

  typedef logic [$clog2(MAX_NCBPS)-1:0] addr_t;

  function automatic int ncpc_of(mod_e m);
    case (m)
      MOD_BPSK:  return 1;
      MOD_QPSK:  return 2;
      MOD_16QAM: return 4;
      default:   return 6;
    endcase
  endfunction

  function automatic int s_of(mod_e m);
    case (m)
      MOD_16QAM: return 2;
      MOD_64QAM: return 3;
      default:   return 1;
    endcase
  endfunction

endpackage

// File: rtl/intlv_index_gen.sv
// Write-address generator: row/col counters, per-block mode latch and mk/jk permutation.
// mk is tracked as s*mk_q + row_r so jk needs only shifts/adds (bypass under INTLV_BYPASS_EN).
module intlv_index_gen
  import wimax_intlv_pkg::*;
#(
  parameter int N_SUB    = N_SUB_DEF,
  parameter int D        = D_DEF,
  parameter int MAX_NCPC = MAX_NCPC_DEF,
  parameter int AW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          xfer,
  input  mod_e          mode,
`ifdef INTLV_BYPASS_EN
  input  logic          bypass,
`endif
  output logic [AW-1:0] jk,
  output logic          first_bit,
  output logic          last_bit,
  output mod_e          blk_mode
);
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  function automatic mod_e legal(mod_e m);
    return (ncpc_of(m) > MAX_NCPC) ? MOD_QPSK : m;
  endfunction

  function automatic logic [AW-1:0] rows_of(mod_e m);
    return AW'(N_SUB * ncpc_of(m) / D);
  endfunction

  function automatic logic [AW-1:0] stepq_of(mod_e m);
    return AW'(N_SUB * ncpc_of(m) / (D * s_of(m)));
  endfunction

  logic [CW-1:0] col;
  logic [AW-1:0] row, row_q, mk_q, perm;
  logic [1:0]    row_r, col_r, s, rem;
  mod_e          mode_lat;

  assign first_bit = (row == '0) && (col == '0);
  assign blk_mode  = first_bit ? legal(mode) : mode_lat;
  assign s         = 2'(s_of(blk_mode));
  assign last_bit  = (col == CW'(D-1)) && (row == rows_of(blk_mode) - AW'(1));

  // (mk + Ncbps - col) mod s reduces to (row - col) mod s since s divides Ncbps and col*step
  always_comb begin
    rem = (row_r >= col_r) ? (row_r - col_r) : (row_r + s - col_r);
    case (s)
      2'd2:    perm = (mk_q << 1) + AW'(rem);
      2'd3:    perm = (mk_q << 1) + mk_q + AW'(rem);
      default: perm = mk_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0; row <= '0; row_q <= '0; row_r <= '0; col_r <= '0; mk_q <= '0;
      mode_lat <= MOD_QPSK;
    end else if (xfer) begin
      if (last_bit) begin
        col <= '0; row <= '0; row_q <= '0; row_r <= '0; col_r <= '0; mk_q <= '0;
      end else if (col == CW'(D-1)) begin
        col   <= '0;
        col_r <= '0;
        row   <= row + AW'(1);
        if (row_r == s - 2'd1) begin
          row_r <= '0;
          row_q <= row_q + AW'(1);
          mk_q  <= row_q + AW'(1);
        end else begin
          row_r <= row_r + 2'd1;
          mk_q  <= row_q;
        end
      end else begin
        col   <= col + CW'(1);
        col_r <= (col_r == s - 2'd1) ? 2'd0 : col_r + 2'd1;
        mk_q  <= mk_q + stepq_of(blk_mode);
      end
      if (first_bit) mode_lat <= blk_mode;
    end
  end

`ifdef INTLV_BYPASS_EN
  logic          byp_lat;
  logic [AW-1:0] k_cnt;

  // k=0 maps to address 0 in both paths, so the latched flag is only needed from k=1
  assign jk = byp_lat ? k_cnt : perm;

  always_ff @(posedge clk) begin
    if (reset) begin
      byp_lat <= 1'b0;
      k_cnt   <= '0;
    end else if (xfer) begin
      k_cnt <= last_bit ? '0 : k_cnt + AW'(1);
      if (first_bit) byp_lat <= bypass;
    end
  end
`else
  assign jk = perm;
`endif

endmodule

// File: rtl/wimax_interleaver_mm.sv
// Multi-mode 802.16 interleaver: ping-pong bit banks, permuted writes, in-order streaming reads.
// Define INTLV_BYPASS_EN to add the per-block bypass input (in-order pass-through).
module wimax_interleaver_mm
  import wimax_intlv_pkg::*;
#(
  parameter int N_SUB    = N_SUB_DEF,
  parameter int D        = D_DEF,
  parameter int MAX_NCPC = MAX_NCPC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       data_in,
  input  logic       valid_in,
  output logic       in_ready,
  output logic       data_out,
  output logic       valid_out,
  input  logic       out_ready
`ifdef INTLV_BYPASS_EN
  ,
  input  logic       bypass
`endif
);
  localparam int NCBPS_MAX = N_SUB * MAX_NCPC;
  localparam int AW        = $clog2(NCBPS_MAX);

  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_e;

  function automatic logic [AW-1:0] last_addr(mod_e m);
    return AW'(N_SUB * ncpc_of(m) - 1);
  endfunction

  logic          mem [2][NCBPS_MAX];
  mod_e          tag [2];
  logic [1:0]    full, full_nxt;
  logic          wr_bank, rd_bank, rd_sel;
  rd_state_e     state, state_nxt;
  logic [AW-1:0] out_addr, addr_nxt, rd_addr, jk;
  logic          load, rd_free, data_nxt, valid_nxt;
  logic          xfer, wr_done, free_other, wr_toggle, first_bit, last_bit;
  mod_e          blk_mode;

  intlv_index_gen #(
    .N_SUB(N_SUB), .D(D), .MAX_NCPC(MAX_NCPC), .AW(AW)
  ) u_index_gen (
    .clk      (clk),
    .reset    (reset),
    .xfer     (xfer),
    .mode     (mod_e'(mode)),
`ifdef INTLV_BYPASS_EN
    .bypass   (bypass),
`endif
    .jk       (jk),
    .first_bit(first_bit),
    .last_bit (last_bit),
    .blk_mode (blk_mode)
  );

  // Write side: one bit per transfer into the current write bank
  assign in_ready   = !reset && !full[wr_bank];
  assign xfer       = valid_in && in_ready;
  assign wr_done    = xfer && last_bit;
  assign free_other = rd_free && (rd_bank != wr_bank);
  // A bank freed in the same cycle counts as empty, so the writer can move onto it at once
  assign wr_toggle  = (wr_done && (!full[~wr_bank] || free_other)) ||
                      (full[wr_bank] && free_other);

  always_ff @(posedge clk) begin
    if (xfer) mem[wr_bank][jk] <= data_in;
  end

  // Read side: oldest full bank streamed through the one-deep output register
  always_comb begin
    state_nxt = state;
    valid_nxt = valid_out;
    data_nxt  = data_out;
    addr_nxt  = out_addr;
    rd_free   = 1'b0;
    load      = 1'b0;
    rd_sel    = rd_bank;
    rd_addr   = out_addr + AW'(1);
    case (state)
      RD_IDLE: begin
        if (full[rd_bank] || (wr_done && wr_bank == rd_bank)) begin
          load      = 1'b1;
          state_nxt = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (out_ready) begin
          if (out_addr == last_addr(tag[rd_bank])) begin
            rd_free = 1'b1;
            rd_sel  = ~rd_bank;
            if (full[~rd_bank] || wr_done) begin
              load = 1'b1;
            end else begin
              state_nxt = RD_IDLE;
              valid_nxt = 1'b0;
            end
          end else begin
            addr_nxt = rd_addr;
            data_nxt = mem[rd_bank][rd_addr];
          end
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
    if (load) begin
      addr_nxt  = '0;
      data_nxt  = mem[rd_sel][0];
      valid_nxt = 1'b1;
    end
  end

  always_comb begin
    full_nxt = full;
    if (rd_free) full_nxt[rd_bank] = 1'b0;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RD_IDLE;
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= 1'b0;
      out_addr  <= '0;
      tag[0]    <= MOD_QPSK;
      tag[1]    <= MOD_QPSK;
    end else begin
      state     <= state_nxt;
      full      <= full_nxt;
      valid_out <= valid_nxt;
      data_out  <= data_nxt;
      out_addr  <= addr_nxt;
      if (wr_toggle) wr_bank <= ~wr_bank;
      if (rd_free) rd_bank <= ~rd_bank;
      if (xfer && first_bit) tag[wr_bank] <= blk_mode;
    end
  end

endmodule

// File: tb/tb_wimax_interleaver_mm.sv
// Scoreboard bench for wimax_interleaver_mm: directed mode/flow-control cases plus randomized blocks.
module tb_wimax_interleaver_mm;
  localparam int NS = 96;
  localparam int DD = 16;

  logic       clk = 1'b0;
  logic       reset, data_in, valid_in, out_ready;
  logic [1:0] mode;
  logic       in_ready, data_out, valid_out;

  int   checks = 0, errors = 0;
  bit   exp_q[$];
  bit   blk[576];
  int   out_total = 0, one_pos = -1;
  bit   rand_rdy = 1'b0;
  bit   prev_stall = 1'b0;
  logic prev_data = 1'b0;

  wimax_interleaver_mm dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .data_in  (data_in),
    .valid_in (valid_in),
    .in_ready (in_ready),
    .data_out (data_out),
    .valid_out(valid_out),
    .out_ready(out_ready)
`ifdef INTLV_BYPASS_EN
    ,
    .bypass   (1'b0)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int ncpc_tb(input int m);
    case (m)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 6;
    endcase
  endfunction

  function automatic int s_tb(input int m);
    case (m)
      2: return 2;
      3: return 3;
      default: return 1;
    endcase
  endfunction

  // Monitor: compares every accepted output against the scoreboard, and checks hold under stall
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", int'(valid_out), 1);
        check("stall_data", int'(data_out), int'(prev_data));
      end
      if (valid_out && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 1, 0);
        else check("data_out", int'(data_out), int'(exp_q.pop_front()));
        if (data_out) one_pos = out_total;
        out_total++;
      end
      prev_stall = valid_out && !out_ready;
      prev_data  = data_out;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(1));
    end
  end

  // Drives n_send bits of blk; a complete block pushes its interleaved image onto the scoreboard
  task automatic send_block(input int m, input int m_later, input int switch_k,
                            input int n_send, input int p_vld);
    int n, s, k, budget, col, row, mk, j;
    bit ob[576];
    n = ncpc_tb(m) * NS;
    s = s_tb(m);
    k = 0;
    budget = 0;
    while (k < n_send) begin
      @(posedge clk); #1;
      valid_in = (p_vld >= 100) || ($urandom_range(99) < p_vld);
      data_in  = blk[k];
      mode     = (k < switch_k) ? 2'(m) : 2'(m_later);
      @(negedge clk);
      if (valid_in && in_ready) k++;
      budget++;
      if (budget > 20000) begin
        check("send_timeout", k, n_send);
        break;
      end
    end
    if (n_send == n) begin
      for (int kk = 0; kk < n; kk++) begin
        col = kk % DD;
        row = kk / DD;
        mk  = (n / DD) * col + row;
        j   = s * (mk / s) + ((mk + n - col) % s);
        ob[j] = blk[kk];
      end
      for (int jj = 0; jj < n; jj++) exp_q.push_back(ob[jj]);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 6000) begin
      @(negedge clk);
      b++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic rand_fill();
    for (int i = 0; i < 576; i++) blk[i] = 1'($urandom_range(1));
  endtask

  task automatic single_one(input string nm, input int m, input int onek, input int exp_pos);
    int n, start;
    n = ncpc_tb(m) * NS;
    wait_drain();
    for (int i = 0; i < 576; i++) blk[i] = (i == onek);
    start   = out_total;
    one_pos = -1;
    send_block(m, m, 1, n, 100);
    check({nm, "_early"}, out_total - start, 0);
    @(negedge clk);
    check({nm, "_latency"}, int'(valid_out), 1);
    wait_drain();
    check({nm, "_pos"}, one_pos - start, exp_pos);
    check({nm, "_count"}, out_total - start, n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int cnt, gaps, b, start, m, n;
    reset = 1'b1; valid_in = 1'b0; data_in = 1'b0; mode = 2'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_data_out", int'(data_out), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_valid_out", int'(valid_out), 0);
    out_ready = 1'b1;

    single_one("qpsk_k1", 1, 1, 12);
    single_one("qam16_k1", 2, 1, 25);
    single_one("qam64_k1", 3, 1, 38);
    single_one("bpsk_k17", 0, 17, 7);

    // Two QPSK blocks with the sink stalled fill both banks
    wait_drain();
    out_ready = 1'b0;
    rand_fill(); send_block(1, 1, 1, 192, 100);
    rand_fill(); send_block(1, 1, 1, 192, 100);
    @(negedge clk);
    check("both_full_in_ready", int'(in_ready), 0);
    check("both_full_valid", int'(valid_out), 1);
    repeat (5) @(negedge clk);
    check("still_full_in_ready", int'(in_ready), 0);
    @(posedge clk); #1 out_ready = 1'b1;
    cnt = 0; gaps = 0; b = 0;
    @(negedge clk);
    while (!in_ready && b < 2000) begin
      if (!valid_out) gaps++;
      cnt++; b++;
      @(negedge clk);
    end
    check("release_cycles", cnt, 192);
    check("release_gaps", gaps, 0);
    rand_fill(); send_block(1, 1, 1, 192, 100);
    wait_drain();

    // Mode change mid-block is ignored; the next block uses the new mode
    start = out_total;
    rand_fill(); send_block(1, 3, 100, 192, 100);
    rand_fill(); send_block(3, 3, 1, 576, 100);
    wait_drain();
    check("mode_switch_count", out_total - start, 768);

    // Randomized modes, valid and ready
    rand_rdy = 1'b1;
    repeat (20) begin
      m = $urandom_range(3);
      n = ncpc_tb(m) * NS;
      rand_fill();
      send_block(m, $urandom_range(3), $urandom_range(1, n - 1), n, 50);
    end
    wait_drain();
    rand_rdy = 1'b0;
    @(posedge clk); #1 out_ready = 1'b0;

    // Reset in the middle of a block while an output is held
    rand_fill(); send_block(2, 2, 1, 384, 100);
    rand_fill(); send_block(1, 1, 1, 50, 100);
    @(negedge clk);
    check("pre_rst_valid", int'(valid_out), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_valid_out", int'(valid_out), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("after_rst_in_ready", int'(in_ready), 1);
    check("after_rst_valid_out", int'(valid_out), 0);
    @(posedge clk); #1 out_ready = 1'b1;
    start = out_total;
    rand_fill(); send_block(3, 0, 7, 576, 100);
    wait_drain();
    check("after_rst_count", out_total - start, 576);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
